delay_line_ctrl: RTL
====================

DELAY_LINE_CTRL -- requirements
Module: delay_line_ctrl

Interface
REQ-001 Parameter WIDTH, 8, sample width in bits.
REQ-002 Parameter DEPTH, 30, number of stages in the controlled delay line.
REQ-003 Reset and clock: reset_n is asynchronous and active-low; the clock is `clock`.
REQ-004 Ports SHALL be, in this order:
- clock  in  1  rising-edge clock.
- reset_n  in  1  async active-low reset.
- ena  in  1  global enable; low freezes the block.
- cfg_wr  in  1  configuration write strobe.
- cfg_len  in  5  requested delay length.
- flush  in  1  single-cycle drain request.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller accepts input.
- out_valid  out  1  delayed sample valid.
- out_ready  in  1  consumer accepts output.
- out_data  out  WIDTH  delayed sample, equal to tap_data.
- shift_en  out  1  delay-line shift strobe.
- tap_sel  out  5  delay-line tap index (0 = newest).
- tap_data  in  WIDTH  delay-line tap output.
- clear  out  1  delay-line clear pulse.
- len  out  5  active delay length.
- cfg_err  out  1  sticky configuration error.
- state  out  2  FSM state: IDLE=0, FILL=1, RUN=2, DRAIN=3.

Function
REQ-005 The FSM SHALL have four states, IDLE, FILL, RUN and DRAIN, plus a count register (0..DEPTH) holding the number of valid samples in the line.
REQ-006 tap_sel SHALL equal count-1 when count>0 and 0 otherwise, so it always addresses the oldest valid sample.
REQ-007 An input transfer happens when ena, in_valid and in_ready are all high; shift_en SHALL equal that condition, combinationally, in the same cycle.
REQ-008 An output transfer happens when ena, out_valid and out_ready are all high.
REQ-009 IDLE: in_ready=ena and out_valid=0.
- An input transfer sets count=1.
- The next state is RUN if len==1, otherwise FILL.
REQ-010 FILL: in_ready=ena and out_valid=0.
- An input transfer increments count.
- Reaching count==len SHALL move the FSM to RUN.
REQ-011 RUN: out_valid=ena&in_valid and in_ready=ena&out_ready.
- A transfer is a lock-step push plus pop, and count stays equal to len.
- Output latency SHALL be exactly len accepted samples.
REQ-012 DRAIN: in_ready=0, shift_en=0, and out_valid=ena&(count>0).
- Each output transfer decrements count.
- The transition to IDLE SHALL occur on the cycle count becomes 0.
REQ-013 clear SHALL pulse high for exactly one cycle on DRAIN->IDLE; clear SHALL be low at all other times.
REQ-014 flush SHALL act as follows in each state:
- In FILL or RUN, flush SHALL move the FSM to DRAIN at the next edge.
- If flush coincides with an input transfer, the sample is accepted first, then the FSM enters DRAIN.
- If flush arrives while count==0, the FSM goes straight to IDLE with a clear pulse.
- In IDLE or DRAIN, flush SHALL be ignored.
REQ-015 cfg_wr SHALL be accepted only in IDLE with ena high.
- len SHALL load cfg_len clamped: 0 loads 1, and any value greater than DEPTH loads DEPTH.
- An accepted write SHALL clear cfg_err.
REQ-016 cfg_wr outside IDLE SHALL leave len unchanged and set cfg_err, which stays high until the next accepted write.
REQ-017 cfg_wr coinciding with an input transfer in IDLE SHALL use the new len for the FILL/RUN decision.
REQ-018 ena low SHALL freeze the block:
- in_ready=0, out_valid=0, shift_en=0.
- No register changes, and flush and cfg_wr are ignored.
REQ-019 out_data SHALL be valid only while out_valid is high and is otherwise don't-care.

Reset
REQ-020 While reset_n is low, the block SHALL hold state=IDLE, count=0, len=DEPTH (30), cfg_err=0 and clear=0.
REQ-021 A reset asserted mid-operation SHALL abandon the FILL/RUN/DRAIN contents without issuing a clear pulse.

Verification
REQ-022 The bench SHALL cover at least these directed scenarios:
- Reset, then cfg_len=3 and stream 1,2,3,4,5 with out_ready=1 -> state goes FILL then RUN after the 3rd sample; outputs are 1,2 on the pushes of 4,5; shift_en is asserted 5 times.
- cfg_len=0 -> len=1; cfg_len=31 -> len=30; with len=1 the first accepted sample moves IDLE->RUN directly.
- cfg_len=4, push 4 samples, then flush -> DRAIN; tap_sel steps 3,2,1,0; four outputs are oldest first; one clear pulse; IDLE.
- cfg_wr during RUN -> len unchanged and cfg_err=1; the next IDLE write clears cfg_err.
- With len=2 in RUN, out_ready=0 for 5 cycles -> in_ready=0, no shift_en, count holds at 2; the next out_ready produces one lock-step transfer.
- ena low for 3 cycles mid-FILL with in_valid=1 -> no transfers and count unchanged; flush pulsed during the ena-low window is ignored.

Source files
------------

// File: rtl/delay_line_ctrl_if.sv
// Signal bundle between delay_line_ctrl, its upstream/downstream handshakes
// and the external delay line it steers.
interface delay_line_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             ena;
    logic             cfg_wr;
    logic [4:0]       cfg_len;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             shift_en;
    logic [4:0]       tap_sel;
    logic [WIDTH-1:0] tap_data;
    logic             clear;
    logic [4:0]       len;
    logic             cfg_err;
    logic [1:0]       state;

    modport master (
        output ena, cfg_wr, cfg_len, flush, in_valid, out_ready, tap_data,
        input  in_ready, out_valid, out_data, shift_en, tap_sel, clear, len, cfg_err, state
    );

    modport slave (
        input  ena, cfg_wr, cfg_len, flush, in_valid, out_ready, tap_data,
        output in_ready, out_valid, out_data, shift_en, tap_sel, clear, len, cfg_err, state
    );
endinterface

// File: rtl/delay_line_ctrl.sv
// Fill/run/drain controller for an external shift-register delay line; tracks
// how many samples are valid and always taps the oldest one.
module delay_line_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 30
) (
    input  logic             clock,
    input  logic             reset_n,
    delay_line_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [4:0] DEPTH_L = 5'(DEPTH);

    state_t           r_state, w_state_nxt;
    logic [4:0]       r_count, w_count_nxt;
    logic [4:0]       r_len, w_len_nxt;
    logic             r_cfg_err, w_cfg_err_nxt;
    logic             r_clear, w_clear_nxt;
    logic             w_in_ready, w_out_valid;
    logic             w_in_xfer, w_out_xfer;
    logic             w_cfg_ok, w_flush_ok;
    logic [4:0]       w_len_eff;
    logic [WIDTH-1:0] w_tap_data;

    function automatic logic [4:0] clamp_len(input logic [4:0] v);
        logic [4:0] lim;
        if (v == 5'd0)
            lim = 5'd1;
        else if (v > DEPTH_L)
            lim = DEPTH_L;
        else
            lim = v;
        return lim;
    endfunction

    // In RUN the push and pop are the same event, so each side waits on the other.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE, FILL: w_in_ready = bus.ena;
            RUN: begin
                w_in_ready  = bus.ena & bus.out_ready;
                w_out_valid = bus.ena & bus.in_valid;
            end
            DRAIN: w_out_valid = bus.ena & (r_count != 5'd0);
            default: ;
        endcase
    end

    assign w_in_xfer  = bus.ena & bus.in_valid & w_in_ready;
    assign w_out_xfer = bus.ena & w_out_valid & bus.out_ready;
    assign w_cfg_ok   = bus.ena & bus.cfg_wr & (r_state == IDLE);
    assign w_flush_ok = bus.ena & bus.flush & ((r_state == FILL) | (r_state == RUN));
    // A write landing with the first sample must steer that sample's FILL/RUN choice.
    assign w_len_eff  = w_cfg_ok ? clamp_len(bus.cfg_len) : r_len;

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_len_nxt     = w_len_eff;
        w_cfg_err_nxt = r_cfg_err;
        w_clear_nxt   = 1'b0;
        if (bus.ena) begin
            if (w_cfg_ok)
                w_cfg_err_nxt = 1'b0;
            else if (bus.cfg_wr)
                w_cfg_err_nxt = 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_in_xfer) begin
                        w_count_nxt = 5'd1;
                        w_state_nxt = (w_len_eff == 5'd1) ? RUN : FILL;
                    end
                end
                FILL: begin
                    if (w_in_xfer) begin
                        w_count_nxt = r_count + 5'd1;
                        if (r_count + 5'd1 == r_len)
                            w_state_nxt = RUN;
                    end
                end
                DRAIN: begin
                    if (w_out_xfer) begin
                        w_count_nxt = r_count - 5'd1;
                        if (r_count == 5'd1) begin
                            w_state_nxt = IDLE;
                            w_clear_nxt = 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            // Flush is evaluated after any coincident push has been counted.
            if (w_flush_ok) begin
                if (w_count_nxt == 5'd0) begin
                    w_state_nxt = IDLE;
                    w_clear_nxt = 1'b1;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_count   <= 5'd0;
            r_len     <= DEPTH_L;
            r_cfg_err <= 1'b0;
            r_clear   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_len     <= w_len_nxt;
            r_cfg_err <= w_cfg_err_nxt;
            r_clear   <= w_clear_nxt;
        end
    end

    assign w_tap_data    = bus.tap_data;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_tap_data;
    assign bus.shift_en  = w_in_xfer;
    assign bus.tap_sel   = (r_count != 5'd0) ? (r_count - 5'd1) : 5'd0;
    assign bus.clear     = r_clear;
    assign bus.len       = r_len;
    assign bus.cfg_err   = r_cfg_err;
    assign bus.state     = r_state;
endmodule
